// File: rtl/dram_cmd_decoder.sv
// DDR4 command-bus decoder with bank tracking and read/write data timing.
// Define DRAM_TIMING_CHECK_EN to build the per-bank tRCD/tRP checkers.
module dram_cmd_decoder #(
  parameter int tRCD = 12,
  parameter int tRP  = 10,
  parameter int tCAS = 12,
  parameter int tWL  = 12
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        CKE,
  input  logic        CS_n,
  input  logic        ACT_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic [1:0]  BG,
  input  logic [1:0]  BA,
  input  logic [13:0] ADDR,
  input  logic        ADDR_17,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [17:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        rd_data_valid,
  output logic        wr_data_expect,
  output logic [15:0] bank_open,
  output logic        err_closed,
  output logic        err_act_open,
  output logic        err_ref_open,
  output logic        err_trcd,
  output logic        err_trp
);

  localparam logic [3:0] C_DESEL = 4'd0;
  localparam logic [3:0] C_ACT   = 4'd1;
  localparam logic [3:0] C_MRS   = 4'd2;
  localparam logic [3:0] C_REF   = 4'd3;
  localparam logic [3:0] C_PRE   = 4'd4;
  localparam logic [3:0] C_WR    = 4'd5;
  localparam logic [3:0] C_RD    = 4'd6;
  localparam logic [3:0] C_ZQ    = 4'd7;
  localparam logic [3:0] C_NOP   = 4'd8;

  logic [3:0]  code;
  logic [3:0]  bk;
  logic [17:0] act_row;
  logic        is_act, is_pre, is_rd, is_wr, is_ref, is_rw;
  logic        hit, act_ok, rw_ok, ap, pre_all, vld;
  logic [17:0] row_q [16];
  logic [tCAS-1:0] rd_sr;
  logic [tWL-1:0]  wr_sr;

  assign bk      = {BG, BA};
  assign act_row = {ADDR_17, RAS_n_A16, CAS_n_A15, WE_n_A14, ADDR};
  assign is_act  = (code == C_ACT);
  assign is_pre  = (code == C_PRE);
  assign is_rd   = (code == C_RD);
  assign is_wr   = (code == C_WR);
  assign is_ref  = (code == C_REF);
  assign is_rw   = is_rd | is_wr;
  assign hit     = bank_open[bk];
  assign act_ok  = is_act & ~hit;
  assign rw_ok   = is_rw & hit;
  assign ap      = rw_ok & ADDR[10];
  assign pre_all = is_pre & ADDR[10];
  assign vld     = (code != C_DESEL) && (code != C_NOP);

  // Combinational decode of the command pins; CKE low forces DESEL.
  always_comb begin
    code = C_DESEL;
    if (CKE && !CS_n) begin
      if (!ACT_n) begin
        code = C_ACT;
      end else begin
        unique case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  code = C_MRS;
          3'b001:  code = C_REF;
          3'b010:  code = C_PRE;
          3'b100:  code = C_WR;
          3'b101:  code = C_RD;
          3'b110:  code = C_ZQ;
          default: code = C_NOP;
        endcase
      end
    end
  end

  // Registered command report, error pulses and bank/row state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cmd_valid    <= 1'b0;
      cmd_code     <= '0;
      cmd_bg       <= '0;
      cmd_ba       <= '0;
      cmd_row      <= '0;
      cmd_col      <= '0;
      err_closed   <= 1'b0;
      err_act_open <= 1'b0;
      err_ref_open <= 1'b0;
      bank_open    <= '0;
      for (int i = 0; i < 16; i++) row_q[i] <= '0;
    end else begin
      cmd_valid    <= vld;
      cmd_code     <= code;
      cmd_bg       <= vld ? BG : 2'b00;
      cmd_ba       <= vld ? BA : 2'b00;
      cmd_row      <= is_act ? act_row : (is_rw ? row_q[bk] : '0);
      cmd_col      <= is_rw ? ADDR[9:0] : '0;
      err_closed   <= is_rw & ~hit;
      err_act_open <= is_act & hit;
      err_ref_open <= is_ref & (|bank_open);
      if (act_ok) begin
        bank_open[bk] <= 1'b1;
        row_q[bk]     <= act_row;
      end
      if (pre_all) bank_open <= '0;
      else if (is_pre || ap) bank_open[bk] <= 1'b0;
    end
  end

  // Data-phase delay lines; a legal access enters at stage 0.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rd_sr <= '0;
      wr_sr <= '0;
    end else begin
      rd_sr[0] <= rw_ok & is_rd;
      wr_sr[0] <= rw_ok & is_wr;
      for (int i = 1; i < tCAS; i++) rd_sr[i] <= rd_sr[i-1];
      for (int i = 1; i < tWL; i++) wr_sr[i] <= wr_sr[i-1];
    end
  end

  assign rd_data_valid  = rd_sr[tCAS-1];
  assign wr_data_expect = wr_sr[tWL-1];

`ifdef DRAM_TIMING_CHECK_EN
  localparam logic [7:0] TRCD_LD = 8'(tRCD - 1);
  localparam logic [7:0] TRP_LD  = 8'(tRP - 1);

  logic [7:0] trcd_cnt [16];
  logic [7:0] trp_cnt  [16];

  // Per-bank saturating down-counters and timing violation pulses.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      err_trcd <= 1'b0;
      err_trp  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        trcd_cnt[i] <= '0;
        trp_cnt[i]  <= '0;
      end
    end else begin
      err_trcd <= rw_ok & (trcd_cnt[bk] != 8'd0);
      err_trp  <= is_act & (trp_cnt[bk] != 8'd0);
      for (int i = 0; i < 16; i++) begin
        if (act_ok && bk == 4'(i))
          trcd_cnt[i] <= TRCD_LD;
        else if (trcd_cnt[i] != 8'd0)
          trcd_cnt[i] <= trcd_cnt[i] - 8'd1;
        if (pre_all || ((is_pre || ap) && bk == 4'(i)))
          trp_cnt[i] <= TRP_LD;
        else if (trp_cnt[i] != 8'd0)
          trp_cnt[i] <= trp_cnt[i] - 8'd1;
      end
    end
  end
`else
  assign err_trcd = 1'b0;
  assign err_trp  = 1'b0;
`endif

endmodule
